// File: rtl/map_tile_scheduler.sv
// Tile-map RAM sequencer for the map sprite renderer: one tile fetch per 8 pixels,
// 2-cycle pixel pipeline, and arbitration of spare RAM cycles between fill and game writes.
module map_tile_scheduler #(
  parameter int MAP_W  = 28,
  parameter int MAP_H  = 31,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              de,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  output logic              wr_ack,
  input  logic              fill_req,
  input  logic [3:0]        fill_code,
  output logic              fill_busy,
  output logic [3:0]        sprite_code,
  output logic [2:0]        sx,
  output logic [2:0]        sy,
  output logic              sprite_de
);

  localparam int                TILES   = MAP_W * MAP_H;
  localparam logic [10:0]       X0_W    = 11'(X0);
  localparam logic [10:0]       Y0_W    = 11'(Y0);
  localparam logic [10:0]       XLIM    = 11'(8 * MAP_W);
  localparam logic [10:0]       YLIM    = 11'(8 * MAP_H);
  localparam logic [ADDR_W:0]   TILES_W = (ADDR_W+1)'(TILES);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(TILES - 1);

  typedef enum logic {IDLE, FILL} state_t;

  // ---- stage 0: map window and render fetch decision ----
  logic [9:0]        lx_p0, ly_p0;
  logic              in_map_p0, fetch_p0;
  logic [ADDR_W-1:0] taddr_p0;

  assign lx_p0     = hpos - X0_W[9:0];
  assign ly_p0     = vpos - Y0_W[9:0];
  assign in_map_p0 = ({1'b0, hpos} >= X0_W) && ({1'b0, lx_p0} < XLIM) &&
                     ({1'b0, vpos} >= Y0_W) && ({1'b0, ly_p0} < YLIM);
  assign fetch_p0  = de && in_map_p0 && (lx_p0[2:0] == 3'd0);
  assign taddr_p0  = ADDR_W'(ly_p0[9:3]) * ADDR_W'(MAP_W) + ADDR_W'(lx_p0[9:3]);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [3:0]        code, code_nxt;
  logic              free, wr_ok;

  assign free      = !fetch_p0;
  assign wr_ok     = {1'b0, wr_addr} < TILES_W;
  assign fill_busy = (state == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      code  <= code_nxt;
    end
  end

  // RAM strobes are combinational, so they are gated by reset to hold reset values.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    if (rst_n) begin
      if (fetch_p0) begin
        ram_re   = 1'b1;
        ram_addr = taddr_p0;
      end
      if (state == IDLE) begin
        if (free && wr_req) begin
          wr_ack    = 1'b1;
          ram_we    = wr_ok;
          ram_addr  = wr_addr;
          ram_wdata = wr_data;
        end
        if (fill_req) begin
          code_nxt  = fill_code;
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end else if (free) begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = code;
        cnt_nxt   = cnt + ADDR_W'(1);
        if (cnt == LAST) state_nxt = IDLE;
      end
    end
  end

  // ---- stage 1: pixel attributes aligned with RAM read latency ----
  logic [2:0] sx_p1, sy_p1;
  logic       de_p1, in_map_p1, fetch_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_p1     <= '0;
      sy_p1     <= '0;
      de_p1     <= 1'b0;
      in_map_p1 <= 1'b0;
      fetch_p1  <= 1'b0;
    end else begin
      sx_p1     <= lx_p0[2:0];
      sy_p1     <= ly_p0[2:0];
      de_p1     <= de;
      in_map_p1 <= in_map_p0;
      fetch_p1  <= fetch_p0;
    end
  end

  // ---- stage 2: sprite outputs ----
  logic [3:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_code <= 4'hF;
      hold        <= 4'hF;
      sx          <= '0;
      sy          <= '0;
      sprite_de   <= 1'b0;
    end else begin
      sx        <= sx_p1;
      sy        <= sy_p1;
      sprite_de <= de_p1;
      if (fetch_p1) begin
        sprite_code <= ram_rdata;
        hold        <= ram_rdata;
      end else if (in_map_p1 && de_p1) begin
        sprite_code <= hold;
      end else begin
        sprite_code <= 4'hF;
      end
    end
  end

endmodule
